conv_output_addr_gen: RTL and testbench

- Parametrised output write-back stage for the systolic conv controller.
- Accepts one result beat per output pixel from the PE array: COLS output channels in parallel.
- Serialises each beat into BRAM writes, one per cycle, at computed output addresses.
- Adds configurable stride, channel-major or pixel-interleaved layout, partial channel groups (do not a multiple of COLS) and config/overflow checking.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_output_addr_gen_out_addr_calc.sv | 42 ++++
 rtl/conv_output_addr_gen.sv | 279 +++++++++++++++++++++++++++
 tb/tb_conv_output_addr_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv controller output write-back path.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic LAYOUT_CH_MAJOR    = 1'b0;
  localparam logic LAYOUT_INTERLEAVED = 1'b1;

  localparam logic [1:0] STRIDE_MIN = 2'd1;
  localparam logic [1:0] STRIDE_MAX = 2'd2;

  function automatic logic stride_legal(input logic [1:0] s);
    return (s >= STRIDE_MIN) && (s <= STRIDE_MAX);
  endfunction

endpackage

// File: rtl/conv_output_addr_gen_out_addr_calc.sv
// Output address for one lane write: channel-major planes or
// pixel-interleaved channels, computed at ADDR_W+DIM_W bits.
module out_addr_calc
  import conv_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                layout,
  input  logic [ADDR_W-1:0]   base,
  input  logic [2*DIM_W-1:0]  plane,
  input  logic [DIM_W-1:0]    do_ch,
  input  logic [2*DIM_W-1:0]  p,
  input  logic [DIM_W:0]      ch,
  output logic [ADDR_W-1:0]   addr
);

  localparam int CW = ADDR_W + DIM_W;

  logic [CW-1:0] base_w;
  logic [CW-1:0] plane_w;
  logic [CW-1:0] do_w;
  logic [CW-1:0] p_w;
  logic [CW-1:0] ch_w;
  logic [CW-1:0] sum;

  // Widen operands, pick the layout formula, truncate to the BRAM address
  always_comb begin
    base_w  = CW'(base);
    plane_w = CW'(plane);
    do_w    = CW'(do_ch);
    p_w     = CW'(p);
    ch_w    = CW'(ch);
    if (layout == LAYOUT_INTERLEAVED) begin
      sum = base_w + p_w * do_w + ch_w;
    end else begin
      sum = base_w + ch_w * plane_w + p_w;
    end
    addr = ADDR_W'(sum);
  end

endmodule

// File: rtl/conv_output_addr_gen.sv
// Output write-back stage: takes one COLS-lane result beat per output pixel
// and serialises it into BRAM writes at layout-dependent addresses.
// The output channel count port is do_ch because 'do' is a keyword.
module conv_output_addr_gen
  import conv_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int COLS   = 4,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIM_W-1:0]        do_ch,
  input  logic [DIM_W-1:0]        dr,
  input  logic [DIM_W-1:0]        dc,
  input  logic [DIM_W-1:0]        dkr,
  input  logic [DIM_W-1:0]        dkc,
  input  logic [1:0]              stride,
  input  logic                    layout,
  input  logic [ADDR_W-1:0]       outaddr,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [COLS*WIDTH-1:0]   pix_data,
  output logic                    wea,
  output logic [ADDR_W-1:0]       memaddr,
  output logic [WIDTH-1:0]        mem_in,
  output logic [DIM_W-1:0]        ir_out,
  output logic [DIM_W-1:0]        ic_out,
  output logic [DIM_W-1:0]        io_out,
  output logic                    busy,
  output logic                    output_finish,
  output logic                    cfg_err
);

  localparam int K_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int P_W   = 2 * DIM_W;
  localparam int CHK_W = ADDR_W + 3 * DIM_W;

  state_e                  state_q, state_d;
  logic [DIM_W-1:0]        dr_q, dr_d, dc_q, dc_d, dkr_q, dkr_d, dkc_q, dkc_d;
  logic [DIM_W-1:0]        do_q, do_d;
  logic [1:0]              stride_q, stride_d;
  logic                    layout_q, layout_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [DIM_W-1:0]        ir_q, ir_d, ic_q, ic_d, io_q, io_d;
  logic [P_W-1:0]          plane_q, plane_d;
  logic [DIM_W-1:0]        g_q, g_d;
  logic [P_W-1:0]          p_q, p_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [COLS*WIDTH-1:0]   data_q, data_d;
  logic                    wea_q, wea_d;
  logic [ADDR_W-1:0]       memaddr_q, memaddr_d;
  logic [WIDTH-1:0]        mem_in_q, mem_in_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    busy_q, busy_d;
  logic                    finish_q, finish_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    sh;
  logic [DIM_W-1:0]        ir_calc, ic_calc;
  logic [P_W-1:0]          plane_calc;
  logic [CHK_W-1:0]        total;
  logic                    cfg_bad;
  logic [DIM_W:0]          grp_base, cur_ch, addr_ch;
  logic                    last_lane, last_group, last_pix;
  logic [K_W-1:0]          next_k;
  logic [ADDR_W-1:0]       calc_addr;

  // Output geometry and the config legality check, full width so nothing wraps
  always_comb begin
    sh         = (stride_q == STRIDE_MAX);
    ir_calc    = ((dr_q - dkr_q) >> sh) + DIM_W'(1);
    ic_calc    = ((dc_q - dkc_q) >> sh) + DIM_W'(1);
    plane_calc = P_W'(ir_calc) * P_W'(ic_calc);
    total      = CHK_W'(base_q) + CHK_W'(do_q) * CHK_W'(plane_calc);
    cfg_bad    = (dkr_q > dr_q) || (dkc_q > dc_q) || !stride_legal(stride_q) ||
                 (do_q == '0) || (total > (CHK_W'(1) << ADDR_W));
  end

  // Lane/channel bookkeeping; addr_ch is the channel of the write launched next
  always_comb begin
    grp_base   = (DIM_W+1)'(g_q) * (DIM_W+1)'(COLS);
    cur_ch     = grp_base + (DIM_W+1)'(k_q);
    last_lane  = (k_q == K_W'(COLS - 1)) ||
                 ((cur_ch + (DIM_W+1)'(1)) >= (DIM_W+1)'(do_q));
    last_group = (grp_base + (DIM_W+1)'(COLS)) >= (DIM_W+1)'(do_q);
    last_pix   = (p_q == plane_q - P_W'(1));
    next_k     = k_q + K_W'(1);
    addr_ch    = (state_q == ST_WRITE) ? (cur_ch + (DIM_W+1)'(1)) : grp_base;
  end

  out_addr_calc #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .layout (layout_q),
    .base   (base_q),
    .plane  (plane_q),
    .do_ch  (do_q),
    .p      (p_q),
    .ch     (addr_ch),
    .addr   (calc_addr)
  );

  // FSM next-state: config latch, setup check, beat accept, lane serialisation
  always_comb begin
    state_d     = state_q;
    dr_d        = dr_q;
    dc_d        = dc_q;
    dkr_d       = dkr_q;
    dkc_d       = dkc_q;
    do_d        = do_q;
    stride_d    = stride_q;
    layout_d    = layout_q;
    base_d      = base_q;
    ir_d        = ir_q;
    ic_d        = ic_q;
    io_d        = io_q;
    plane_d     = plane_q;
    g_d         = g_q;
    p_d         = p_q;
    k_d         = k_q;
    data_d      = data_q;
    wea_d       = 1'b0;
    memaddr_d   = memaddr_q;
    mem_in_d    = mem_in_q;
    pix_ready_d = pix_ready_q;
    busy_d      = busy_q;
    finish_d    = 1'b0;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dr_d      = dr;
          dc_d      = dc;
          dkr_d     = dkr;
          dkc_d     = dkc;
          do_d      = do_ch;
          stride_d  = stride;
          layout_d  = layout;
          base_d    = outaddr;
          cfg_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        ir_d    = ir_calc;
        ic_d    = ic_calc;
        io_d    = do_q;
        plane_d = plane_calc;
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          g_d         = '0;
          p_d         = '0;
          k_d         = '0;
          pix_ready_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pix_valid && pix_ready_q) begin
          data_d      = pix_data;
          k_d         = '0;
          wea_d       = 1'b1;
          memaddr_d   = calc_addr;
          mem_in_d    = pix_data[0 +: WIDTH];
          pix_ready_d = 1'b0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_lane) begin
          k_d = '0;
          if (last_pix) begin
            p_d = '0;
            g_d = g_q + DIM_W'(1);
            if (last_group) begin
              finish_d = 1'b1;
              state_d  = ST_FIN;
            end else begin
              pix_ready_d = 1'b1;
              state_d     = ST_WAIT;
            end
          end else begin
            p_d         = p_q + P_W'(1);
            pix_ready_d = 1'b1;
            state_d     = ST_WAIT;
          end
        end else begin
          k_d       = next_k;
          wea_d     = 1'b1;
          memaddr_d = calc_addr;
          mem_in_d  = data_q[next_k*WIDTH +: WIDTH];
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dr_q        <= '0;
      dc_q        <= '0;
      dkr_q       <= '0;
      dkc_q       <= '0;
      do_q        <= '0;
      stride_q    <= '0;
      layout_q    <= 1'b0;
      base_q      <= '0;
      ir_q        <= '0;
      ic_q        <= '0;
      io_q        <= '0;
      plane_q     <= '0;
      g_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      data_q      <= '0;
      wea_q       <= 1'b0;
      memaddr_q   <= '0;
      mem_in_q    <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dr_q        <= dr_d;
      dc_q        <= dc_d;
      dkr_q       <= dkr_d;
      dkc_q       <= dkc_d;
      do_q        <= do_d;
      stride_q    <= stride_d;
      layout_q    <= layout_d;
      base_q      <= base_d;
      ir_q        <= ir_d;
      ic_q        <= ic_d;
      io_q        <= io_d;
      plane_q     <= plane_d;
      g_q         <= g_d;
      p_q         <= p_d;
      k_q         <= k_d;
      data_q      <= data_d;
      wea_q       <= wea_d;
      memaddr_q   <= memaddr_d;
      mem_in_q    <= mem_in_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign pix_ready     = pix_ready_q;
  assign wea           = wea_q;
  assign memaddr       = memaddr_q;
  assign mem_in        = mem_in_q;
  assign ir_out        = ir_q;
  assign ic_out        = ic_q;
  assign io_out        = io_q;
  assign busy          = busy_q;
  assign output_finish = finish_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_conv_output_addr_gen.sv
// Scoreboard bench for conv_output_addr_gen: expected writes are queued as
// beats are driven and popped by a monitor whenever the DUT asserts wea.
module tb_conv_output_addr_gen;

  localparam int WIDTH  = 8;
  localparam int COLS   = 4;
  localparam int DIM_W  = 8;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [DIM_W-1:0]      do_ch = '0;
  logic [DIM_W-1:0]      dr = '0;
  logic [DIM_W-1:0]      dc = '0;
  logic [DIM_W-1:0]      dkr = '0;
  logic [DIM_W-1:0]      dkc = '0;
  logic [1:0]            stride = '0;
  logic                  layout = 1'b0;
  logic [ADDR_W-1:0]     outaddr = '0;
  logic                  pix_valid = 1'b0;
  logic                  pix_ready;
  logic [COLS*WIDTH-1:0] pix_data = '0;
  logic                  wea;
  logic [ADDR_W-1:0]     memaddr;
  logic [WIDTH-1:0]      mem_in;
  logic [DIM_W-1:0]      ir_out;
  logic [DIM_W-1:0]      ic_out;
  logic [DIM_W-1:0]      io_out;
  logic                  busy;
  logic                  output_finish;
  logic                  cfg_err;

  int  vecCount = 0;
  int  missCount = 0;
  int  finishCount = 0;
  wr_t expQ[$];
  int  writeLog[$];

  conv_output_addr_gen #(
    .WIDTH  (WIDTH),
    .COLS   (COLS),
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .do_ch         (do_ch),
    .dr            (dr),
    .dc            (dc),
    .dkr           (dkr),
    .dkc           (dkc),
    .stride        (stride),
    .layout        (layout),
    .outaddr       (outaddr),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .wea           (wea),
    .memaddr       (memaddr),
    .mem_in        (mem_in),
    .ir_out        (ir_out),
    .ic_out        (ic_out),
    .io_out        (io_out),
    .busy          (busy),
    .output_finish (output_finish),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    assert (got === exp) else begin
      missCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int logAt(input int idx);
    if (idx < writeLog.size()) return writeLog[idx];
    return -1;
  endfunction

  // Monitor: every DUT write is matched against the head of the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (rst && output_finish) finishCount++;
    if (rst && wea) begin
      writeLog.push_back(int'(memaddr));
      if (expQ.size() == 0) begin
        checkOutput("writeExpected", 32'(expQ.size() != 0), 1);
      end else begin
        e = expQ.pop_front();
        checkOutput("memaddr", memaddr, e.addr);
        checkOutput("mem_in", mem_in, e.data);
      end
    end
  end

  task automatic applyStimulus(input logic [DIM_W-1:0] drV, input logic [DIM_W-1:0] dcV,
                               input logic [DIM_W-1:0] dkrV, input logic [DIM_W-1:0] dkcV,
                               input logic [1:0] strV, input logic layV,
                               input logic [DIM_W-1:0] doV, input logic [ADDR_W-1:0] baseV);
    @(negedge clk);
    dr = drV; dc = dcV; dkr = dkrV; dkc = dkcV;
    stride = strV; layout = layV; do_ch = doV; outaddr = baseV;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendBeat(input logic [COLS*WIDTH-1:0] beat);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pix_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("beatReady", 32'(ok), 1);
    pix_data  = beat;
    pix_valid = 1'b1;
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  task automatic pushBeat(input int g, input int p, input int plane, input int doV,
                          input int baseV, input bit layV, input logic [COLS*WIDTH-1:0] beat);
    wr_t e;
    int  ch;
    for (int k = 0; k < COLS; k++) begin
      ch = g * COLS + k;
      if (ch < doV) begin
        e.addr = layV ? ADDR_W'(baseV + p * doV + ch) : ADDR_W'(baseV + ch * plane + p);
        e.data = beat[k*WIDTH +: WIDTH];
        expQ.push_back(e);
      end
    end
  endtask

  task automatic runConv(input int drV, input int dcV, input int dkrV, input int dkcV,
                         input int strV, input bit layV, input int doV, input int baseV,
                         input bit idleFirst, input bit pokeStart);
    int irV, icV, plane, groups, f0;
    bit seen = 1'b0;
    logic [COLS*WIDTH-1:0] beat;
    writeLog.delete();
    f0 = finishCount;
    applyStimulus(DIM_W'(drV), DIM_W'(dcV), DIM_W'(dkrV), DIM_W'(dkcV),
                  2'(strV), layV, DIM_W'(doV), ADDR_W'(baseV));
    irV    = ((drV - dkrV) >> (strV - 1)) + 1;
    icV    = ((dcV - dkcV) >> (strV - 1)) + 1;
    plane  = irV * icV;
    groups = (doV + COLS - 1) / COLS;
    if (idleFirst) begin
      repeat (11) @(negedge clk);
      checkOutput("idleReady", pix_ready, 1);
      checkOutput("idleNoWrites", writeLog.size(), 0);
    end
    for (int g = 0; g < groups; g++) begin
      for (int p = 0; p < plane; p++) begin
        if (pokeStart && g == 0 && p == 1) begin
          @(negedge clk);
          start = 1'b1; do_ch = 8'd9; outaddr = 10'd7;
          @(negedge clk);
          start = 1'b0;
        end
        beat = $urandom;
        pushBeat(g, p, plane, doV, baseV, layV, beat);
        sendBeat(beat);
      end
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (output_finish) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("finishSeen", 32'(seen), 1);
    @(negedge clk);
    checkOutput("finishPulses", finishCount - f0, 1);
    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("busyAfter", busy, 0);
    checkOutput("cfgErrLegal", cfg_err, 0);
    checkOutput("ir_out", ir_out, irV);
    checkOutput("ic_out", ic_out, icV);
    checkOutput("io_out", io_out, doV);
  endtask

  initial begin
    logic [COLS*WIDTH-1:0] beat;

    $display("[TB] reset with start held");
    start = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstWea", wea, 0);
    checkOutput("rstMemaddr", memaddr, 0);
    checkOutput("rstMemIn", mem_in, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReady", pix_ready, 0);
    checkOutput("rstFinish", output_finish, 0);
    checkOutput("rstCfgErr", cfg_err, 0);
    checkOutput("rstIrIcIo", {ir_out, ic_out, io_out}, 0);
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idleReady0", pix_ready, 0);
    checkOutput("idleBusy0", busy, 0);

    $display("[TB] basic channel-major run");
    runConv(8, 8, 3, 3, 1, 1'b0, 4, 100, 1'b1, 1'b0);
    checkOutput("basicWrites", writeLog.size(), 144);
    checkOutput("basicBeat0Lane2", logAt(2), 172);
    checkOutput("basicLastAddr", logAt(143), 243);

    $display("[TB] partial group, interleaved, start poked while busy");
    runConv(8, 8, 3, 3, 1, 1'b1, 6, 0, 1'b0, 1'b1);
    checkOutput("ilvWrites", writeLog.size(), 216);
    checkOutput("ilvP5Ch5", logAt(155), 35);
    checkOutput("ilvLastAddr", logAt(215), 215);

    $display("[TB] illegal stride");
    writeLog.delete();
    applyStimulus(8'd8, 8'd8, 8'd3, 8'd3, 2'd3, 1'b0, 8'd4, 10'd0);
    @(negedge clk);
    checkOutput("stride3CfgErr", cfg_err, 1);
    checkOutput("stride3Busy", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("stride3Writes", writeLog.size(), 0);
    checkOutput("stride3Finish", finishCount, 2);

    $display("[TB] address overflow");
    applyStimulus(8'd28, 8'd28, 8'd4, 8'd4, 2'd1, 1'b0, 8'd4, 10'd1000);
    @(negedge clk);
    checkOutput("ovfCfgErr", cfg_err, 1);
    checkOutput("ovfBusy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("ovfWrites", writeLog.size(), 0);

    $display("[TB] stride 2 run clears the error");
    runConv(8, 8, 3, 3, 2, 1'b0, 3, 500, 1'b0, 1'b0);
    checkOutput("stride2Ir", ir_out, 3);
    checkOutput("stride2Ic", ic_out, 3);
    checkOutput("stride2Writes", writeLog.size(), 27);

    $display("[TB] reset during write");
    writeLog.delete();
    applyStimulus(8'd8, 8'd8, 8'd3, 8'd3, 2'd1, 1'b0, 8'd4, 10'd100);
    beat = $urandom;
    pushBeat(0, 0, 36, 4, 100, 1'b0, beat);
    sendBeat(beat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wea) break;
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("abortWea", wea, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortMemaddr", memaddr, 0);
    checkOutput("abortWrites", writeLog.size(), 1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
    runConv(8, 8, 3, 3, 1, 1'b0, 4, 100, 1'b0, 1'b0);
    checkOutput("rerunFirstAddr", logAt(0), 100);
    checkOutput("rerunWrites", writeLog.size(), 144);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
